// File: rtl/i2s_dac_serializer_if.sv
// Sample handshake and I2S output bundle for i2s_dac_serializer.
// The sample source is the master; the serializer is the slave.
interface i2s_dac_serializer_if #(
   parameter int SAMPLE_WIDTH = 16
);
   logic signed [SAMPLE_WIDTH-1:0] sample_l;
   logic signed [SAMPLE_WIDTH-1:0] sample_r;
   logic                           sample_valid;
   logic                           sample_clk_en;
   logic                           i2s_sclk;
   logic                           i2s_lrclk;
   logic                           i2s_sdata;
   logic                           underrun;

   modport master (
      output sample_l, sample_r, sample_valid,
      input  sample_clk_en, i2s_sclk, i2s_lrclk, i2s_sdata, underrun
   );

   modport slave (
      input  sample_l, sample_r, sample_valid,
      output sample_clk_en, i2s_sclk, i2s_lrclk, i2s_sdata, underrun
   );
endinterface

// File: rtl/i2s_dac_serializer.sv
// Stereo I2S serializer: 256 clk per frame, 64 sclk, one-slot MSB delay after lrclk.
// Samples land in hold registers at any time and are loaded into frame registers at frame start.
module i2s_dac_serializer #(
   parameter int SAMPLE_WIDTH = 16,
   parameter int FRAME_CLKS   = 256
) (
   input logic                 clk,
   input logic                 reset_n,
   i2s_dac_serializer_if.slave bus
);
   if (FRAME_CLKS != 256) begin : g_bad_frame_clks
      $error("i2s_dac_serializer: FRAME_CLKS must be 256");
   end
   if (SAMPLE_WIDTH < 8 || SAMPLE_WIDTH > 31) begin : g_bad_sample_width
      $error("i2s_dac_serializer: SAMPLE_WIDTH must be 8..31");
   end

   logic [7:0]              cnt_q, cnt_d;
   logic [SAMPLE_WIDTH-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
   logic [SAMPLE_WIDTH-1:0] frame_l_q, frame_l_d, frame_r_q, frame_r_d;
   logic                    pending_q, pending_d;
   logic                    sdata_q, sdata_d;
   logic                    sample_clk_en_q, sample_clk_en_d;
   logic                    underrun_q, underrun_d;
   logic                    frame_start;
   logic [4:0]              slot;
   logic [SAMPLE_WIDTH-1:0] word;
   logic [31:0]             slots;

   assign cnt_d       = cnt_q + 8'd1;
   assign frame_start = (cnt_d == 8'd0);

   always_comb begin
      hold_l_d   = hold_l_q;
      hold_r_d   = hold_r_q;
      frame_l_d  = frame_l_q;
      frame_r_d  = frame_r_q;
      pending_d  = pending_q;
      underrun_d = 1'b0;
      if (bus.sample_valid) begin
         hold_l_d  = bus.sample_l;
         hold_r_d  = bus.sample_r;
         pending_d = 1'b1;
      end
      if (frame_start) begin
         // A sample arriving on the frame-start edge bypasses the hold stage.
         pending_d  = 1'b0;
         underrun_d = !bus.sample_valid && !pending_q;
         if (bus.sample_valid) begin
            frame_l_d = bus.sample_l;
            frame_r_d = bus.sample_r;
         end else if (pending_q) begin
            frame_l_d = hold_l_q;
            frame_r_d = hold_r_q;
         end
      end
   end

   // Bit 31 is slot 0 (always 0), bits 30.. hold the word MSB first, the rest pad with 0.
   always_comb begin
      slot  = cnt_d[6:2];
      word  = cnt_d[7] ? frame_r_d : frame_l_d;
      slots = '0;
      slots[30 -: SAMPLE_WIDTH] = word;
      sdata_d = sdata_q;
      if (cnt_d[1:0] == 2'b00) begin
         sdata_d = slots[~slot];
      end
   end

   assign sample_clk_en_d = (cnt_d == 8'd192);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q           <= '0;
         hold_l_q        <= '0;
         hold_r_q        <= '0;
         frame_l_q       <= '0;
         frame_r_q       <= '0;
         pending_q       <= 1'b0;
         sdata_q         <= 1'b0;
         sample_clk_en_q <= 1'b0;
         underrun_q      <= 1'b0;
      end else begin
         cnt_q           <= cnt_d;
         hold_l_q        <= hold_l_d;
         hold_r_q        <= hold_r_d;
         frame_l_q       <= frame_l_d;
         frame_r_q       <= frame_r_d;
         pending_q       <= pending_d;
         sdata_q         <= sdata_d;
         sample_clk_en_q <= sample_clk_en_d;
         underrun_q      <= underrun_d;
      end
   end

   assign bus.i2s_sclk      = cnt_q[1];
   assign bus.i2s_lrclk     = cnt_q[7];
   assign bus.i2s_sdata     = sdata_q;
   assign bus.sample_clk_en = sample_clk_en_q;
   assign bus.underrun      = underrun_q;
endmodule

// File: tb/tb_i2s_dac_serializer.sv
// Directed bench for i2s_dac_serializer: decodes each frame from the pins and
// compares words, strobes and clocks against hand-computed values.
module tb_i2s_dac_serializer;
   logic clk;
   logic reset_n;
   logic [7:0] tb_cnt;
   int checks;
   int failures;

   i2s_dac_serializer_if #(.SAMPLE_WIDTH(16)) bus ();

   i2s_dac_serializer #(
      .SAMPLE_WIDTH(16),
      .FRAME_CLKS  (256)
   ) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Bench-side frame position, reset together with the DUT.
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) tb_cnt <= 8'd0;
      else          tb_cnt <= tb_cnt + 8'd1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_idle(input string tag);
      check($sformatf("%s sclk", tag), 32'(bus.i2s_sclk), 32'd0);
      check($sformatf("%s lrclk", tag), 32'(bus.i2s_lrclk), 32'd0);
      check($sformatf("%s sdata", tag), 32'(bus.i2s_sdata), 32'd0);
      check($sformatf("%s sample_clk_en", tag), 32'(bus.sample_clk_en), 32'd0);
      check($sformatf("%s underrun", tag), 32'(bus.underrun), 32'd0);
   endtask

   // Observe one full frame starting at cnt=0, optionally driving up to two sample_valid pulses.
   task automatic run_frame(input string tag, input logic [15:0] exp_l, input logic [15:0] exp_r,
                            input logic exp_ur,
                            input int at0, input logic [15:0] l0, input logic [15:0] r0,
                            input int at1, input logic [15:0] l1, input logic [15:0] r1);
      logic [31:0] got_l, got_r;
      logic        held;
      logic [7:0]  c;
      int sclk_err, lr_err, en_err, stable_err, ur_other, guard;
      logic        ur0;
      got_l = '0; got_r = '0; held = 1'b0;
      sclk_err = 0; lr_err = 0; en_err = 0; stable_err = 0; ur_other = 0; ur0 = 1'b0;
      guard = 0;
      while (tb_cnt != 8'd0 && guard < 300) begin
         @(negedge clk);
         guard++;
      end
      checks++;
      assert (guard < 300) else begin
         failures++;
         $error("FAIL %s sync observed=timeout expected=frame_start", tag);
      end
      for (int i = 0; i < 256; i++) begin
         bus.sample_valid = 1'b0;
         if (i == at0) begin
            bus.sample_valid = 1'b1; bus.sample_l = l0; bus.sample_r = r0;
         end
         if (i == at1) begin
            bus.sample_valid = 1'b1; bus.sample_l = l1; bus.sample_r = r1;
         end
         c = tb_cnt;
         if (bus.i2s_sclk !== c[1]) sclk_err++;
         if (bus.i2s_lrclk !== c[7]) lr_err++;
         if (bus.sample_clk_en !== (c == 8'd192)) en_err++;
         if (c == 8'd0) ur0 = bus.underrun;
         else if (bus.underrun !== 1'b0) ur_other++;
         if (c[1:0] == 2'd1) held = bus.i2s_sdata;
         if (c[1:0] == 2'd2 || c[1:0] == 2'd3) begin
            if (bus.i2s_sdata !== held) stable_err++;
         end
         if (c[1:0] == 2'd2) begin
            if (c[7]) got_r[5'd31 - c[6:2]] = bus.i2s_sdata;
            else      got_l[5'd31 - c[6:2]] = bus.i2s_sdata;
         end
         @(negedge clk);
      end
      bus.sample_valid = 1'b0;
      check($sformatf("%s left_word", tag), got_l, {1'b0, exp_l, 15'd0});
      check($sformatf("%s right_word", tag), got_r, {1'b0, exp_r, 15'd0});
      check($sformatf("%s underrun_at_start", tag), 32'(ur0), 32'(exp_ur));
      check($sformatf("%s underrun_elsewhere", tag), 32'(ur_other), 32'd0);
      check($sformatf("%s sclk_bad_cycles", tag), 32'(sclk_err), 32'd0);
      check($sformatf("%s lrclk_bad_cycles", tag), 32'(lr_err), 32'd0);
      check($sformatf("%s sample_clk_en_bad_cycles", tag), 32'(en_err), 32'd0);
      check($sformatf("%s sdata_unstable", tag), 32'(stable_err), 32'd0);
   endtask

   initial begin
      checks = 0;
      failures = 0;
      reset_n = 1'b0;
      bus.sample_valid = 1'b0;
      bus.sample_l = '0;
      bus.sample_r = '0;
      repeat (3) @(negedge clk);
      check_idle("reset");
      reset_n = 1'b1;

      run_frame("f0_zero", 16'h0000, 16'h0000, 1'b0, -1, '0, '0, -1, '0, '0);
      run_frame("f1_idle", 16'h0000, 16'h0000, 1'b1, -1, '0, '0, -1, '0, '0);
      run_frame("f2_req", 16'h0000, 16'h0000, 1'b1, 192, 16'h8001, 16'h7FFE, -1, '0, '0);
      run_frame("f3_8001", 16'h8001, 16'h7FFE, 1'b0, 192, 16'h8001, 16'h7FFE, -1, '0, '0);
      run_frame("f4_8001", 16'h8001, 16'h7FFE, 1'b0, 192, 16'h5A5A, 16'hA5A5, -1, '0, '0);
      run_frame("f5_5a5a", 16'h5A5A, 16'hA5A5, 1'b0, -1, '0, '0, -1, '0, '0);
      run_frame("f6_repeat", 16'h5A5A, 16'hA5A5, 1'b1, 200, 16'h0001, 16'h0002,
                230, 16'hFFFF, 16'h1111);
      run_frame("f7_last_wins", 16'hFFFF, 16'h1111, 1'b0, 255, 16'h1234, 16'h4321, -1, '0, '0);
      run_frame("f8_bypass", 16'h1234, 16'h4321, 1'b0, -1, '0, '0, -1, '0, '0);
      run_frame("f9_after_bypass", 16'h1234, 16'h4321, 1'b1, -1, '0, '0, -1, '0, '0);

      // Leave a pending sample behind, then reset mid-frame at cnt=100.
      for (int i = 0; i < 100; i++) begin
         bus.sample_valid = (i == 50);
         bus.sample_l = 16'h7777;
         bus.sample_r = 16'h7777;
         @(negedge clk);
      end
      bus.sample_valid = 1'b0;
      reset_n = 1'b0;
      #1;
      check_idle("midreset_now");
      repeat (3) @(negedge clk);
      check_idle("midreset_held");
      reset_n = 1'b1;
      run_frame("r0_zero", 16'h0000, 16'h0000, 1'b0, -1, '0, '0, -1, '0, '0);
      run_frame("r1_idle", 16'h0000, 16'h0000, 1'b1, -1, '0, '0, -1, '0, '0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/i2s_dac_serializer.md
I2S_DAC_SERIALIZER -- requirements
Module: i2s_dac_serializer

Interface
REQ-001 The module SHALL have parameter SAMPLE_WIDTH, default 16, giving the signed PCM sample width; legal range is 8..31.
REQ-002 The module SHALL have parameter FRAME_CLKS, default 256, giving the clk cycles per stereo frame; it is fixed at 256, and any other value SHALL be rejected at elaboration.
REQ-003 Port clk, input, 1 bit: master clock (12.727 MHz); single clock domain.
REQ-004 Port reset_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-005 Port sample_l, input, SAMPLE_WIDTH bits: signed left-channel sample.
REQ-006 Port sample_r, input, SAMPLE_WIDTH bits: signed right-channel sample.
REQ-007 Port sample_valid, input, 1 bit: qualifies sample_l and sample_r for one clk.
REQ-008 Port sample_clk_en, output, 1 bit: one-cycle request pulse for the next sample, once per frame.
REQ-009 Port i2s_sclk, output, 1 bit: DAC bit clock, clk/4.
REQ-010 Port i2s_lrclk, output, 1 bit: word select; 0 selects left, 1 selects right.
REQ-011 Port i2s_sdata, output, 1 bit: serial data, MSB first.
REQ-012 Port underrun, output, 1 bit: one-cycle pulse when a frame starts with no new sample.

Function
REQ-013 An 8-bit free-running frame counter cnt SHALL increment every clk and wrap from 255 to 0.
REQ-014 All outputs SHALL be registered, with no combinational path from any input to any output.
REQ-015 i2s_sclk SHALL equal cnt[1], giving 64 sclk periods per frame.
REQ-016 i2s_lrclk SHALL equal cnt[7], so left occupies cnt 0..127 and right occupies cnt 128..255.
REQ-017 The slot index SHALL be slot = cnt[6:2], giving 0..31 within each half-frame.
REQ-018 i2s_sdata SHALL follow I2S framing: slot 0 is 0; slots 1..SAMPLE_WIDTH carry bits [SAMPLE_WIDTH-1]..[0] of the active channel's frame register; slots above SAMPLE_WIDTH are 0.
REQ-019 i2s_sdata SHALL change only on cycles where cnt[1:0]=00, i.e. at sclk falling edges, and SHALL be stable while i2s_sclk is high.
REQ-020 sample_clk_en SHALL be 1 exactly in the cycle where cnt=192 and 0 otherwise.
REQ-021 When sample_valid=1, sample_l and sample_r SHALL be captured into the hold registers, and a pending flag SHALL be set.
REQ-022 At each frame start, i.e. the cycle where cnt becomes 0, the hold registers SHALL be copied into the left/right frame registers and the pending flag SHALL be cleared.
REQ-023 If sample_valid=1 in the same cycle as the frame-start copy, the incoming sample SHALL bypass to the frame registers, and pending SHALL remain cleared.
REQ-024 If pending=0 at frame start, the frame registers SHALL retain their previous sample and underrun SHALL pulse for 1 cycle.
REQ-025 Multiple sample_valid pulses within one frame SHALL overwrite the hold registers, so the last one wins, with no error indication.
REQ-026 The frame registers SHALL be stable for all 256 cycles of a frame.
REQ-027 Latency from a sample_valid pulse at cnt=192 to the left MSB on i2s_sdata SHALL be 68 clk: MSB is driven at cnt=4, which is slot 1.

Reset
REQ-028 While reset_n=0, cnt, the hold registers, the frame registers and pending SHALL be 0.
REQ-029 While reset_n=0, i2s_sclk, i2s_lrclk, i2s_sdata, sample_clk_en and underrun SHALL be 0.
REQ-030 After reset_n deasserts, counting SHALL start from cnt=0 on the first clk edge.
REQ-031 Reset asserted mid-frame SHALL abort the frame immediately, with no partial word completion.
REQ-032 The first frame after reset SHALL transmit zeros and SHALL NOT pulse underrun.

Verification
REQ-033 Free-run with no samples: sclk period is 4 clk, lrclk period is 256 clk, sample_clk_en is high once per 256 clk at cnt=192, and underrun pulses every frame from the second frame on.
REQ-034 Answer each sample_clk_en with sample_l=16'h8001 and sample_r=16'h7FFE: the decoded left word is 8001 and the right word is 7FFE, with the MSB one sclk after each lrclk edge and trailing slots 0.
REQ-035 Pulse sample_valid exactly in the cycle where cnt becomes 0 with L=16'h1234: the same frame carries 1234 (bypass) and no underrun.
REQ-036 Send two valids in one frame (L=16'h0001, then L=16'hFFFF): the next frame carries FFFF.
REQ-037 Skip one sample after L=16'h5A5A: that frame repeats 5A5A, underrun pulses once, and the following sample resumes normally.
REQ-038 Assert reset_n=0 at cnt=100 mid-left-word: all outputs are 0 within the reset window, and after release cnt restarts at 0 and sdata is 0 for the whole first frame.
